// File: rtl/jump_pkg.sv
// jump_pkg: shared decode constants, jump-select encodings and FSM states for branch_redirect_ctrl
package jump_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [1:0] JSEL_SEQ = 2'd0;
  localparam logic [1:0] JSEL_J   = 2'd1;
  localparam logic [1:0] JSEL_JR  = 2'd2;
  localparam logic [1:0] JSEL_RAS = 2'd3;
  typedef enum logic [1:0] {IDLE, WAIT_RS, FLUSH, VERIFY} state_t;
endpackage

// File: rtl/jump_ras.sv
// jump_ras: circular return-address stack; a push when full overwrites the oldest entry
module jump_ras #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW:0] cnt;
  assign top = mem[wp - PW'(1)];
  assign empty = cnt == '0;
  // write pointer wraps freely; occupancy saturates at DEPTH so overflow drops the oldest
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      cnt <= '0;
    end else if (push) begin
      wp <= wp + PW'(1);
      cnt <= cnt == (PW+1)'(DEPTH) ? cnt : cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      wp <= wp - PW'(1);
      cnt <= cnt - (PW+1)'(1);
    end
  // storage needs no reset: entries are only read while occupancy is nonzero
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: J/JAL/JR redirect FSM with fetch flush; define BRANCH_RAS_EN to build the return-address stack
module branch_redirect_ctrl
  import jump_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              stall_in,
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  input  logic [4:0]        rs_idx,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] rs_data,
  input  logic              rs_ready,
  output logic [1:0]        jsel,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if,
  output logic              stall_id,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_pc
);
  if (ADDR_W < 28 || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || RAS_DEPTH < 2 || RAS_DEPTH > 16 ||
      (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_param
    $error("branch_redirect_ctrl: parameter out of range");
  end
  localparam logic [2:0] FL = 3'(FLUSH_CYCLES - 1);
  state_t state, nstate;
  logic [2:0] fcnt;
  logic [1:0] rsel;
  logic [ADDR_W-1:0] pred, rtgt, ras_top, pc4, pc8, jt;
  logic is_j, is_jal, is_jr, predict, go, rd, ras_empty;
  assign pc4 = pc + ADDR_W'(4);
  assign pc8 = pc + ADDR_W'(8);
  assign jt = (pc4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({imm26, 2'b00});
  assign is_j = opcode == OP_J;
  assign is_jal = opcode == OP_JAL;
  assign is_jr = opcode == OP_SPECIAL && func == FN_JR;
  assign predict = is_jr && rs_idx == 5'd31 && !ras_empty;
  assign go = state == IDLE && id_valid && !stall_in;
  assign stall_id = rst_n && ((state == IDLE && id_valid && is_jr && !predict && !rs_ready) ||
                              (state == WAIT_RS && !rs_ready));
`ifdef BRANCH_RAS_EN
  jump_ras #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk(clk),
    .rst_n(rst_n),
    .push(go && is_jal),
    .pop(go && predict),
    .din(pc8),
    .top(ras_top),
    .empty(ras_empty)
  );
`else
  assign ras_top = '0;
  assign ras_empty = 1'b1;
`endif
  // decide whether this edge issues a redirect, where to, and the next state
  always_comb begin
    rd = 1'b0;
    rsel = JSEL_JR;
    rtgt = rs_data;
    nstate = state;
    case (state)
      IDLE:
        if (id_valid) begin
          if (is_j || is_jal) begin
            rd = 1'b1;
            rsel = JSEL_J;
            rtgt = jt;
            nstate = FLUSH;
          end else if (predict) begin
            rd = 1'b1;
            rsel = JSEL_RAS;
            rtgt = ras_top;
            nstate = VERIFY;
          end else if (is_jr) begin
            rd = rs_ready;
            nstate = rs_ready ? FLUSH : WAIT_RS;
          end
        end
      WAIT_RS: begin
        rd = rs_ready;
        nstate = rs_ready ? FLUSH : WAIT_RS;
      end
      FLUSH: nstate = fcnt == 3'd0 ? IDLE : FLUSH;
      VERIFY:
        if (rs_ready) begin
          rd = rs_data != pred;
          nstate = (rd || fcnt != 3'd0) ? FLUSH : IDLE;
        end
      default: nstate = IDLE;
    endcase
  end
  // state, flush counter and registered outputs; pulses never survive a stall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      fcnt <= 3'd0;
      pred <= '0;
      jsel <= JSEL_SEQ;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      flush_if <= 1'b0;
      link_we <= 1'b0;
      link_pc <= '0;
    end else begin
      redirect_valid <= !stall_in && rd;
      link_we <= go && is_jal;
      if (!stall_in) begin
        state <= nstate;
        jsel <= rd ? rsel : JSEL_SEQ;
        flush_if <= rd || fcnt != 3'd0;
        fcnt <= rd ? FL : (fcnt != 3'd0 ? fcnt - 3'd1 : 3'd0);
        if (rd) redirect_pc <= rtgt;
        if (state == IDLE) pred <= ras_top;
        if (go && is_jal) link_pc <= pc8;
      end
    end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed scenarios plus random traffic against a behavioural jump-redirect model
module tb_branch_redirect_ctrl;
  localparam int FC = 3;
  localparam int RD = 4;
  localparam logic [5:0] OPJ = 6'd2, OPJAL = 6'd3;
  logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, stall_in = 1'b0, rs_ready = 1'b0;
  logic [5:0] opcode = '0, func = '0;
  logic [4:0] rs_idx = '0;
  logic [25:0] imm26 = '0;
  logic [31:0] pc = '0, rs_data = '0;
  logic [1:0] jsel;
  logic redirect_valid, flush_if, stall_id, link_we;
  logic [31:0] redirect_pc, link_pc;
  int n_tests = 0, n_fail = 0;
  bit mon_on = 1'b0;
  bit m_wait = 1'b0, m_ver = 1'b0, e_rv = 1'b0, e_lw = 1'b0, e_fl = 1'b0;
  int m_left = 0;
  logic [1:0] e_js = '0;
  logic [31:0] m_pred = '0, e_rpc = '0, e_lpc = '0;
  logic [31:0] ras[$];

  branch_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(FC), .RAS_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall_in(stall_in), .opcode(opcode),
    .func(func), .rs_idx(rs_idx), .imm26(imm26), .pc(pc), .rs_data(rs_data), .rs_ready(rs_ready),
    .jsel(jsel), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_if(flush_if),
    .stall_id(stall_id), .link_we(link_we), .link_pc(link_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit jr();
    return opcode == 6'd0 && func == 6'h08;
  endfunction

  function automatic bit pok();
`ifdef BRANCH_RAS_EN
    return jr() && rs_idx == 5'd31 && ras.size() != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_sid();
    bit idle;
    idle = !e_fl && !m_wait && !m_ver;
    return rst_n && ((idle && id_valid && jr() && !pok() && !rs_ready) || (m_wait && !rs_ready));
  endfunction

  always @(negedge rst_n) begin
    m_wait = 0; m_ver = 0; m_left = 0;
    e_rv = 0; e_lw = 0; e_fl = 0; e_js = 0;
    ras.delete();
  end

  // behavioural model: one instruction in flight, flush as a countdown, RAS as a queue
  always @(posedge clk) if (rst_n) begin
    bit r, idle;
    logic [1:0] s;
    logic [31:0] t;
    idle = !e_fl && !m_wait && !m_ver;
    r = 0; s = 0; t = 0;
    e_rv = 0; e_lw = 0;
    if (!stall_in) begin
      if (idle && id_valid) begin
        if (opcode == OPJ || opcode == OPJAL) begin
          r = 1; s = 1;
          t = ((pc + 32'd4) & 32'hF000_0000) | {4'b0, imm26, 2'b00};
          if (opcode == OPJAL) begin
            e_lw = 1; e_lpc = pc + 32'd8;
`ifdef BRANCH_RAS_EN
            if (ras.size() == RD) void'(ras.pop_front());
            ras.push_back(pc + 32'd8);
`endif
          end
        end else if (jr()) begin
          if (pok()) begin
            r = 1; s = 3; t = ras.pop_back(); m_pred = t; m_ver = 1;
          end else if (rs_ready) begin
            r = 1; s = 2; t = rs_data;
          end else m_wait = 1;
        end
      end else if (m_wait && rs_ready) begin
        m_wait = 0; r = 1; s = 2; t = rs_data;
      end else if (m_ver && rs_ready) begin
        m_ver = 0;
        if (rs_data != m_pred) begin r = 1; s = 2; t = rs_data; end
      end
      if (r) begin e_fl = 1; m_left = FC - 1; end
      else if (m_left > 0) begin e_fl = 1; m_left--; end
      else e_fl = 0;
      e_rv = r;
      e_js = r ? s : 2'd0;
      if (r) e_rpc = t;
    end
  end

  always @(negedge clk) if (mon_on) begin
    chk("m_jsel", jsel, e_js);
    chk("m_redirect_valid", redirect_valid, e_rv);
    chk("m_flush_if", flush_if, e_fl);
    chk("m_link_we", link_we, e_lw);
    chk("m_stall_id", stall_id, exp_sid());
    if (e_rv) chk("m_redirect_pc", redirect_pc, e_rpc);
    if (e_lw) chk("m_link_pc", link_pc, e_lpc);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                     input logic [25:0] im, input logic [31:0] p, input logic [31:0] d, input logic rdy);
    id_valid = v; opcode = op; func = fn; rs_idx = rs; imm26 = im; pc = p; rs_data = d; rs_ready = rdy;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nfl, ns;
    logic [31:0] ev;
    drv(1, 6'd0, 6'h08, 5'd3, 0, 32'h0040_0000, 0, 0);
    repeat (3) step();
    mon_on = 1;
    @(negedge clk);
    chk("rst_jsel", jsel, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_flush_if", flush_if, 0);
    chk("rst_stall_id", stall_id, 0);
    chk("rst_link_we", link_we, 0);
    step();
    drv(1, OPJ, 0, 0, 26'h0100004, 32'h0040_0010, 0, 0);
    rst_n = 1;
    step(); id_valid = 0;
    @(negedge clk);
    chk("j_redirect_valid", redirect_valid, 1);
    chk("j_redirect_pc", redirect_pc, 32'h0040_0010);
    chk("j_jsel", jsel, 1);
    nfl = int'(flush_if);
    repeat (6) begin step(); @(negedge clk); nfl += int'(flush_if); end
    chk("j_flush_cycles", nfl, FC);
    step();
    drv(1, 6'd0, 6'h08, 5'd5, 0, 32'h0040_0020, 32'h1000, 0);
    ns = 0;
    repeat (3) begin @(negedge clk); ns += int'(stall_id); step(); end
    rs_ready = 1;
    @(negedge clk); ns += int'(stall_id);
    chk("jr_stall_cycles", ns, 3);
    step(); id_valid = 0;
    @(negedge clk);
    chk("jr_redirect_valid", redirect_valid, 1);
    chk("jr_redirect_pc", redirect_pc, 32'h1000);
    chk("jr_jsel", jsel, 2);
    repeat (5) step();
    drv(1, OPJAL, 0, 0, 26'h0100040, 32'h0040_0000, 0, 0);
    step(); id_valid = 0;
    @(negedge clk);
    chk("jal_link_we", link_we, 1);
    chk("jal_link_pc", link_pc, 32'h0040_0008);
    chk("jal_redirect_pc", redirect_pc, 32'h0040_0100);
    repeat (5) step();
    drv(1, 6'd0, 6'h08, 5'd31, 0, 32'h0040_0040, 32'h0040_0100, 0);
    step(); rs_ready = 1;
    @(negedge clk);
`ifdef BRANCH_RAS_EN
    chk("ras_jsel", jsel, 3);
    chk("ras_redirect_pc", redirect_pc, 32'h0040_0008);
    chk("ras_redirect_valid", redirect_valid, 1);
`else
    chk("noras_redirect_valid", redirect_valid, 0);
`endif
    step(); id_valid = 0;
    @(negedge clk);
    chk("verify_redirect_valid", redirect_valid, 1);
    chk("verify_redirect_pc", redirect_pc, 32'h0040_0100);
    chk("verify_jsel", jsel, 2);
    repeat (5) step();
    for (int k = 0; k < 5; k++) begin
      drv(1, OPJAL, 0, 0, 0, 32'h0040_0000 + 32'(k) * 32'h100, 0, 0);
      step(); id_valid = 0;
      @(negedge clk);
      chk("jal5_link_we", link_we, 1);
      repeat (5) step();
    end
    for (int k = 4; k >= 0; k--) begin
      ev = k > 0 ? 32'h0040_0008 + 32'(k) * 32'h100 : 32'h2000;
      drv(1, 6'd0, 6'h08, 5'd31, 0, 32'h0050_0000, ev, 1);
      step(); id_valid = 0;
      @(negedge clk);
      chk("pop_redirect_pc", redirect_pc, ev);
`ifdef BRANCH_RAS_EN
      chk("pop_jsel", jsel, k > 0 ? 2'd3 : 2'd2);
`else
      chk("pop_jsel", jsel, 2);
`endif
      repeat (5) step();
    end
    drv(1, OPJ, 0, 0, 26'h0100004, 32'h0040_0010, 0, 0);
    step(); id_valid = 0;
    @(negedge clk);
    chk("fl_redirect_valid", redirect_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("rstfl_flush_if", flush_if, 0);
    chk("rstfl_jsel", jsel, 0);
    chk("rstfl_redirect_pc", redirect_pc, 0);
    @(posedge clk); #1;
    rst_n = 1;
    drv(1, OPJ, 0, 0, 26'h0000010, 32'h1000_0000, 0, 0);
    step(); id_valid = 0;
    @(negedge clk);
    chk("post_rst_redirect_valid", redirect_valid, 1);
    chk("post_rst_redirect_pc", redirect_pc, 32'h1000_0040);
    chk("post_rst_flush_if", flush_if, 1);
    repeat (5) step();
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = $urandom_range(0, 5);
      rst_n = $urandom_range(0, 299) != 0;
      id_valid = $urandom_range(0, 3) != 0;
      stall_in = $urandom_range(0, 9) == 0;
      opcode = k == 0 ? OPJ : k == 1 ? OPJAL : k < 5 ? 6'd0 : 6'($urandom);
      func = (k == 2 || k == 3) ? 6'h08 : 6'($urandom);
      rs_idx = $urandom_range(0, 1) != 0 ? 5'd31 : 5'($urandom);
      imm26 = 26'($urandom);
      pc = $urandom_range(0, 3) == 0 ? $urandom : 32'h0040_0000 + 32'($urandom_range(0, 7)) * 4;
      rs_ready = $urandom_range(0, 2) != 0;
      rs_data = $urandom_range(0, 1) != 0 ? 32'h0040_0008 + 32'($urandom_range(0, 7)) * 4 : $urandom;
      step();
    end
    rst_n = 1; stall_in = 0; id_valid = 0;
    repeat (8) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
